intr_bank_ctrl: RTL and testbench
=================================

Name: intr_bank_ctrl

Overview:
- Interrupt/mode sequencer for the 64-byte program ROM.
- The ROM is split into four 16-byte banks: normal, software interrupt, exception and hardware interrupt.
- The block selects the active bank, forms the 6-bit physical address from the core's 4-bit logical PC, and sequences handler entry and exit through a saved return PC.
- It sits between the core's fetch/decode logic and the memory's addr.phys_addr input.

Parameters:
- IRQ_ENABLE, 1: 0 permanently masks irq_i.
- HANDLER_ENTRY, 4'h0: logical PC loaded on handler entry; the same offset is used in every bank.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pc_i  in  4  current logical PC from the core
- swi_i  in  1  one-cycle pulse from the decoder: software-interrupt instruction at pc_i
- exc_i  in  1  one-cycle pulse: exception raised by the instruction at pc_i
- irq_i  in  1  external hardware interrupt request, level-sensitive
- iret_i  in  1  one-cycle pulse: return-from-interrupt instruction decoded
- phys_addr_o  out  6  physical address to memory, equal to {bank_o, pc_i}
- bank_o  out  2  active bank: 0 normal, 1 SWI, 2 EXC, 3 HWI
- redirect_o  out  1  core must load redirect_pc_o as its next PC
- redirect_pc_o  out  4  redirect target
- in_handler_o  out  1  high in ENTER, HANDLER and EXIT
- irq_pending_o  out  1  irq request seen but not yet taken
- double_fault_o  out  1  sticky: exception raised while in a handler

Behaviour:
- Single clock domain. All registers update on rising clk. Reset is synchronous and active-high.
- Reset values: state RUN, bank_o 0, saved_pc 0, redirect_o 0, redirect_pc_o 0, in_handler_o 0, irq_pending_o 0, double_fault_o 0.
- phys_addr_o is combinational: {bank_q, pc_i}. The memory reads combinationally, so fetch latency is zero.
- irq_eff = irq_i & IRQ_ENABLE (after the synchronizer when IRQ_SYNC_EN is defined).
- FSM states: RUN, ENTER, HANDLER, EXIT.
- RUN, event sampled, priority exc_i > irq_eff > swi_i:
  - exc_i: bank_q <= 2, saved_pc <= pc_i (faulting instruction is re-executed).
  - irq_eff: bank_q <= 3, saved_pc <= pc_i (instruction at pc_i not yet retired).
  - swi_i alone: bank_q <= 1, saved_pc <= pc_i + 1 (mod 16; 4'hF wraps to 4'h0).
  - A swi_i that loses to exc_i or irq_eff is dropped. Because saved_pc = pc_i, it re-executes after return.
  - Any event -> ENTER. No event: remain in RUN. iret_i in RUN is ignored.
- ENTER, exactly 1 cycle:
  - redirect_o = 1, redirect_pc_o = HANDLER_ENTRY; bank_o already holds the new bank.
  - Unconditionally -> HANDLER. Inputs are ignored this cycle, except that exc_i sets double_fault_o.
- HANDLER:
  - exc_i: sets double_fault_o; state and bank are unchanged. exc_i wins over a simultaneous iret_i.
  - swi_i is ignored.
  - iret_i: bank_q <= 0 -> EXIT.
- EXIT, exactly 1 cycle:
  - redirect_o = 1, redirect_pc_o = saved_pc, bank_o = 0.
  - -> RUN. Events in this cycle are ignored; a level irq is taken in the following RUN cycle.
- Outside ENTER and EXIT: redirect_o = 0. redirect_pc_o holds its last value.
- irq_pending_o = irq_eff & (state != RUN). No nesting: a held irq is serviced after return.
- double_fault_o clears only on rst.
- Reset mid-operation: the next state is RUN with bank 0. No EXIT redirect is issued and saved_pc is cleared.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: irq_i passes through a 2-flop synchronizer (reset to 0) before irq_eff. This adds 2 cycles from irq_i rise to the RUN-state decision, and irq_pending_o uses the synchronized value.
- Undefined: irq_i is used directly with no added latency.

Test Plan:
- Reset, then pc_i=4'h3 -> phys_addr_o=6'h03, bank_o=0, redirect_o=0, all flags 0.
- swi_i pulse at pc_i=4'hF -> next cycle: ENTER, bank_o=1, redirect_o=1, redirect_pc_o=0, phys_addr_o={2'd1,pc_i}. Later iret_i -> EXIT with redirect_pc_o=4'h0 (wrap), bank_o=0.
- exc_i, irq_i and swi_i together at pc_i=4'h5 -> bank_o=2. After iret_i, redirect_pc_o=4'h5; irq still high, so 1 cycle after EXIT, ENTER with bank_o=3.
- In HANDLER, exc_i and iret_i in the same cycle -> double_fault_o=1, stays in HANDLER with bank unchanged; a later iret_i exits and double_fault_o remains 1 until rst.
- irq_i high during HANDLER (bank 1) -> irq_pending_o=1. Set IRQ_ENABLE=0 and raise irq_i in RUN -> no entry, irq_pending_o=0.
- rst asserted in HANDLER (bank 3) -> next cycle bank_o=0, redirect_o=0, in_handler_o=0. With IRQ_SYNC_EN defined, irq_i rise in RUN -> ENTER 3 cycles later, not 1.

Source files
------------

// File: rtl/intr_bank_ctrl.sv
// Interrupt/mode sequencer for the 64-byte program ROM: selects the active 16-byte bank and sequences handler entry/exit.
// Optional feature: define IRQ_SYNC_EN to pass irq_i through a 2-flop synchronizer before use.
module intr_bank_ctrl #(
  parameter bit         IRQ_ENABLE    = 1'b1,
  parameter logic [3:0] HANDLER_ENTRY = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pc_i,
  input  logic       swi_i,
  input  logic       exc_i,
  input  logic       irq_i,
  input  logic       iret_i,
  output logic [5:0] phys_addr_o,
  output logic [1:0] bank_o,
  output logic       redirect_o,
  output logic [3:0] redirect_pc_o,
  output logic       in_handler_o,
  output logic       irq_pending_o,
  output logic       double_fault_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_EXIT    = 2'd3
  } state_t;

  localparam logic [1:0] BANK_NORMAL = 2'd0;
  localparam logic [1:0] BANK_SWI    = 2'd1;
  localparam logic [1:0] BANK_EXC    = 2'd2;
  localparam logic [1:0] BANK_HWI    = 2'd3;

  state_t     r_state;
  state_t     w_stateNext;
  logic [1:0] r_bank;
  logic [1:0] w_bankNext;
  logic [3:0] r_savedPc;
  logic [3:0] w_savedPcNext;
  logic [3:0] r_redirectPc;
  logic [3:0] w_redirectPcNext;
  logic       r_doubleFault;
  logic       w_doubleFaultSet;
  logic       w_irqRaw;
  logic       w_irqEff;

`ifdef IRQ_SYNC_EN
  logic [1:0] r_irqSync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irqSync <= 2'b00;
    end else begin
      r_irqSync <= {r_irqSync[0], irq_i};
    end
  end

  assign w_irqRaw = r_irqSync[1];
`else
  assign w_irqRaw = irq_i;
`endif

  assign w_irqEff = w_irqRaw & IRQ_ENABLE;

  // The faulting or interrupted instruction re-executes on return; a SWI resumes after itself.
  always_comb begin
    w_stateNext      = r_state;
    w_bankNext       = r_bank;
    w_savedPcNext    = r_savedPc;
    w_redirectPcNext = r_redirectPc;
    w_doubleFaultSet = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (exc_i) begin
          w_stateNext      = ST_ENTER;
          w_bankNext       = BANK_EXC;
          w_savedPcNext    = pc_i;
          w_redirectPcNext = HANDLER_ENTRY;
        end else if (w_irqEff) begin
          w_stateNext      = ST_ENTER;
          w_bankNext       = BANK_HWI;
          w_savedPcNext    = pc_i;
          w_redirectPcNext = HANDLER_ENTRY;
        end else if (swi_i) begin
          w_stateNext      = ST_ENTER;
          w_bankNext       = BANK_SWI;
          w_savedPcNext    = pc_i + 4'd1;
          w_redirectPcNext = HANDLER_ENTRY;
        end
      end
      ST_ENTER: begin
        w_stateNext      = ST_HANDLER;
        w_doubleFaultSet = exc_i;
      end
      ST_HANDLER: begin
        if (exc_i) begin
          w_doubleFaultSet = 1'b1;
        end else if (iret_i) begin
          w_stateNext      = ST_EXIT;
          w_bankNext       = BANK_NORMAL;
          w_redirectPcNext = r_savedPc;
        end
      end
      ST_EXIT: begin
        w_stateNext = ST_RUN;
      end
      default: begin
        w_stateNext = ST_RUN;
        w_bankNext  = BANK_NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_bank        <= BANK_NORMAL;
      r_savedPc     <= 4'h0;
      r_redirectPc  <= 4'h0;
      r_doubleFault <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_bank        <= w_bankNext;
      r_savedPc     <= w_savedPcNext;
      r_redirectPc  <= w_redirectPcNext;
      r_doubleFault <= r_doubleFault | w_doubleFaultSet;
    end
  end

  assign phys_addr_o    = {r_bank, pc_i};
  assign bank_o         = r_bank;
  assign redirect_o     = (r_state == ST_ENTER) || (r_state == ST_EXIT);
  assign redirect_pc_o  = r_redirectPc;
  assign in_handler_o   = (r_state != ST_RUN);
  assign irq_pending_o  = w_irqEff & (r_state != ST_RUN);
  assign double_fault_o = r_doubleFault;

endmodule

// File: tb/tb_intr_bank_ctrl.sv
// Directed, table-driven self-checking bench for intr_bank_ctrl, plus hand sequences for IRQ masking and latency.
module tb_intr_bank_ctrl;

  typedef struct {
    logic [3:0] pc;
    logic       swi;
    logic       exc;
    logic       irq;
    logic       iret;
    logic       rstIn;
    logic [1:0] expBank;
    logic       expRedirect;
    logic [3:0] expRedirectPc;
    logic       expInHandler;
    logic       expPending;
    logic       expDoubleFault;
  } vec_t;

`ifdef IRQ_SYNC_EN
  localparam int IRQ_LATENCY = 3;
`else
  localparam int IRQ_LATENCY = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] pc;
  logic       swi;
  logic       exc;
  logic       irq;
  logic       iret;

  logic [5:0] physAddr;
  logic [1:0] bank;
  logic       redirect;
  logic [3:0] redirectPc;
  logic       inHandler;
  logic       irqPending;
  logic       doubleFault;

  logic [5:0] mPhysAddr;
  logic [1:0] mBank;
  logic       mRedirect;
  logic [3:0] mRedirectPc;
  logic       mInHandler;
  logic       mIrqPending;
  logic       mDoubleFault;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  intr_bank_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc),
    .swi_i         (swi),
    .exc_i         (exc),
    .irq_i         (irq),
    .iret_i        (iret),
    .phys_addr_o   (physAddr),
    .bank_o        (bank),
    .redirect_o    (redirect),
    .redirect_pc_o (redirectPc),
    .in_handler_o  (inHandler),
    .irq_pending_o (irqPending),
    .double_fault_o(doubleFault)
  );

  intr_bank_ctrl #(.IRQ_ENABLE(1'b0)) u_dutMasked (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc),
    .swi_i         (swi),
    .exc_i         (exc),
    .irq_i         (irq),
    .iret_i        (iret),
    .phys_addr_o   (mPhysAddr),
    .bank_o        (mBank),
    .redirect_o    (mRedirect),
    .redirect_pc_o (mRedirectPc),
    .in_handler_o  (mInHandler),
    .irq_pending_o (mIrqPending),
    .double_fault_o(mDoubleFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic [3:0] vPc, input logic vSwi, input logic vExc,
                        input logic vIrq, input logic vIret, input logic vRst,
                        input logic [1:0] eBank, input logic eRed, input logic [3:0] eRpc,
                        input logic eInh, input logic ePend, input logic eDf);
    vec_t v;
    v.pc = vPc; v.swi = vSwi; v.exc = vExc; v.irq = vIrq; v.iret = vIret; v.rstIn = vRst;
    v.expBank = eBank; v.expRedirect = eRed; v.expRedirectPc = eRpc;
    v.expInHandler = eInh; v.expPending = ePend; v.expDoubleFault = eDf;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    pc   = v.pc;
    swi  = v.swi;
    exc  = v.exc;
    irq  = v.irq;
    iret = v.iret;
    rst  = v.rstIn;
    #1;
  endtask

  initial begin
    rst = 1'b1; pc = 4'h0; swi = 1'b0; exc = 1'b0; irq = 1'b0; iret = 1'b0;

    //      pc   swi exc irq iret rst  bank red rpc  inh pend df
    addVec(4'h3, 0, 0, 0, 0, 0,  2'd0, 0, 4'h0, 0, 0, 0);
    addVec(4'hF, 1, 0, 0, 0, 0,  2'd0, 0, 4'h0, 0, 0, 0);
    addVec(4'hF, 0, 0, 0, 0, 0,  2'd1, 1, 4'h0, 1, 0, 0);
    addVec(4'h0, 0, 0, 0, 0, 0,  2'd1, 0, 4'h0, 1, 0, 0);
    addVec(4'h1, 0, 0, 1, 0, 0,  2'd1, 0, 4'h0, 1, 1, 0);
    addVec(4'h2, 0, 0, 0, 1, 0,  2'd1, 0, 4'h0, 1, 0, 0);
    addVec(4'h2, 0, 0, 0, 0, 0,  2'd0, 1, 4'h0, 1, 0, 0);
    addVec(4'h0, 0, 0, 0, 0, 0,  2'd0, 0, 4'h0, 0, 0, 0);
    addVec(4'h5, 1, 1, 1, 0, 0,  2'd0, 0, 4'h0, 0, 0, 0);
    addVec(4'h5, 0, 0, 1, 0, 0,  2'd2, 1, 4'h0, 1, 1, 0);
    addVec(4'h0, 0, 0, 1, 0, 0,  2'd2, 0, 4'h0, 1, 1, 0);
    addVec(4'h1, 0, 0, 1, 1, 0,  2'd2, 0, 4'h0, 1, 1, 0);
    addVec(4'h1, 0, 0, 1, 0, 0,  2'd0, 1, 4'h5, 1, 1, 0);
    addVec(4'h5, 0, 0, 1, 0, 0,  2'd0, 0, 4'h5, 0, 0, 0);
    addVec(4'h5, 0, 0, 0, 0, 0,  2'd3, 1, 4'h0, 1, 0, 0);
    addVec(4'h0, 0, 0, 0, 0, 0,  2'd3, 0, 4'h0, 1, 0, 0);
    addVec(4'h1, 0, 1, 0, 1, 0,  2'd3, 0, 4'h0, 1, 0, 0);
    addVec(4'h2, 0, 0, 0, 0, 0,  2'd3, 0, 4'h0, 1, 0, 1);
    addVec(4'h3, 0, 0, 0, 1, 0,  2'd3, 0, 4'h0, 1, 0, 1);
    addVec(4'h5, 0, 0, 0, 0, 0,  2'd0, 1, 4'h5, 1, 0, 1);
    addVec(4'h6, 0, 0, 0, 0, 0,  2'd0, 0, 4'h5, 0, 0, 1);
    addVec(4'h6, 0, 0, 1, 0, 0,  2'd0, 0, 4'h5, 0, 0, 1);
    addVec(4'h6, 0, 0, 0, 0, 0,  2'd3, 1, 4'h0, 1, 0, 1);
    addVec(4'h6, 0, 0, 0, 0, 1,  2'd3, 0, 4'h0, 1, 0, 1);
    addVec(4'h7, 0, 0, 0, 0, 0,  2'd0, 0, 4'h0, 0, 0, 0);
    addVec(4'h8, 1, 0, 0, 0, 0,  2'd0, 0, 4'h0, 0, 0, 0);
    addVec(4'h8, 0, 0, 0, 0, 0,  2'd1, 1, 4'h0, 1, 0, 0);
    addVec(4'h0, 1, 0, 0, 1, 0,  2'd1, 0, 4'h0, 1, 0, 0);
    addVec(4'h0, 0, 0, 0, 0, 0,  2'd0, 1, 4'h9, 1, 0, 0);
    addVec(4'h9, 0, 0, 0, 1, 0,  2'd0, 0, 4'h9, 0, 0, 0);
    addVec(4'h9, 1, 0, 0, 0, 0,  2'd0, 0, 4'h9, 0, 0, 0);
    addVec(4'h9, 0, 1, 0, 0, 0,  2'd1, 1, 4'h0, 1, 0, 0);
    addVec(4'h0, 0, 0, 0, 1, 0,  2'd1, 0, 4'h0, 1, 0, 1);
    addVec(4'h0, 0, 0, 0, 0, 0,  2'd0, 1, 4'hA, 1, 0, 1);
    addVec(4'hA, 0, 0, 0, 0, 0,  2'd0, 0, 4'hA, 0, 0, 1);

    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d phys", i), {2'b00, physAddr}, {2'b00, vecs[i].expBank, vecs[i].pc});
      checkOutput($sformatf("v%0d bank", i), {6'd0, bank}, {6'd0, vecs[i].expBank});
      checkOutput($sformatf("v%0d redirect", i), {7'd0, redirect}, {7'd0, vecs[i].expRedirect});
      checkOutput($sformatf("v%0d redirect_pc", i), {4'd0, redirectPc}, {4'd0, vecs[i].expRedirectPc});
      checkOutput($sformatf("v%0d in_handler", i), {7'd0, inHandler}, {7'd0, vecs[i].expInHandler});
      checkOutput($sformatf("v%0d irq_pending", i), {7'd0, irqPending}, {7'd0, vecs[i].expPending});
      checkOutput($sformatf("v%0d double_fault", i), {7'd0, doubleFault}, {7'd0, vecs[i].expDoubleFault});
    end

    // Fresh reset, then hold irq high: the masked instance must never enter, the normal one after IRQ_LATENCY cycles.
    @(negedge clk);
    rst = 1'b1; swi = 1'b0; exc = 1'b0; iret = 1'b0; irq = 1'b0;
    @(negedge clk);
    rst = 1'b0; pc = 4'h4; irq = 1'b1;
    #1;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput($sformatf("lat k%0d in_handler", k), {7'd0, inHandler}, {7'd0, (k >= IRQ_LATENCY)});
      checkOutput($sformatf("lat k%0d redirect", k), {7'd0, redirect}, {7'd0, (k == IRQ_LATENCY)});
      checkOutput($sformatf("mask k%0d bank", k), {6'd0, mBank}, 8'd0);
      checkOutput($sformatf("mask k%0d in_handler", k), {7'd0, mInHandler}, 8'd0);
      checkOutput($sformatf("mask k%0d irq_pending", k), {7'd0, mIrqPending}, 8'd0);
      checkOutput($sformatf("mask k%0d phys", k), {2'b00, mPhysAddr}, 8'h04);
    end
    checkOutput("lat bank", {6'd0, bank}, 8'd3);
    checkOutput("lat irq_pending", {7'd0, irqPending}, 8'd1);
    irq = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
